cmos_capture_rgb565: RTL and testbench
======================================

CMOS_CAPTURE_RGB565 -- requirements
Module: cmos_capture_rgb565

Interface
REQ-001 Parameter SKIP_FRAMES, default 10: number of vsync rising edges discarded after reset while the sensor settles.
REQ-002 Parameter H_ACTIVE, default 640: expected pixels per line, used for the error check.
REQ-003 Parameter V_ACTIVE, default 480: expected lines per frame, used for the error check.
REQ-004 cmos0_pclk  in  1  sensor pixel clock; all logic runs on its rising edge.
REQ-005 sys_rst_n  in  1  reset: asynchronous, active-low.
REQ-006 cam_vsync  in  1  raw DVP frame sync, active-high.
REQ-007 cam_href  in  1  raw DVP line-valid, active-high.
REQ-008 cam_data  in  8  raw DVP byte: RGB565 high byte first.
REQ-009 cap_en  in  1  capture enable, sampled only at frame boundaries.
REQ-010 cmos_frame_vsync  out  1  gated, aligned vsync.
REQ-011 cmos_frame_href  out  1  gated, aligned href.
REQ-012 cmos_frame_data  out  16  packed RGB565 pixel.
REQ-013 cmos_frame_valid  out  1  single-cycle pixel strobe.
REQ-014 frame_cnt  out  8  number of completed captured frames, wraps 255->0.
REQ-015 err_flags  out  2  sticky: bit0 = line length error, bit1 = frame length error.

Function
REQ-016 Input stage: cam_vsync, cam_href and cam_data SHALL be registered once; all further logic SHALL use only the registered copies.
REQ-017 vsync rising edge (vs_rise) SHALL be detected from the registered vsync and its one-cycle delayed copy.
REQ-018 FSM states SHALL be SKIP, WAIT, ACTIVE; state after reset SHALL be SKIP.
REQ-019 SKIP->WAIT SHALL occur on the SKIP_FRAMES-th vs_rise; the skip counter SHALL saturate.
REQ-020 WAIT->ACTIVE SHALL occur on vs_rise with cap_en=1.
REQ-021 ACTIVE->WAIT SHALL occur on vs_rise with cap_en=0; cap_en changes mid-frame SHALL NOT truncate the frame.
REQ-022 Byte toggle SHALL clear while registered href=0; the first byte of a pair SHALL load data[15:8], the second SHALL load data[7:0].
REQ-023 On the second byte in ACTIVE: cmos_frame_data SHALL update and cmos_frame_valid SHALL pulse high for 1 cycle, 2 cycles after that byte is at the pins.
REQ-024 A dangling odd byte at href fall SHALL be discarded with no strobe.
REQ-025 cmos_frame_href and cmos_frame_vsync SHALL be the raw inputs delayed 2 cycles, ANDed with (state==ACTIVE), so they stay aligned with valid.
REQ-026 Outside ACTIVE: valid=0, href=0, vsync=0, and data SHALL hold its last value.
REQ-027 The pixel counter SHALL count strobes per line and SHALL clear on href fall; the line counter SHALL count href falls and SHALL clear on vs_rise.
REQ-028 frame_cnt SHALL increment on each vs_rise that ends an ACTIVE frame.

Reset
REQ-029 Reset SHALL clear every register: outputs 0, data 16'h0000, frame_cnt 0, err_flags 2'b00, state SKIP, skip counter 0.
REQ-030 Reset asserted mid-line SHALL abort the line immediately with no strobe; after release, the skip sequence SHALL restart in full.

Configuration
REQ-031 Macro CMOS_CAPTURE_ERR_EN defined: in ACTIVE, err_flags[0] SHALL set when a line ends with pixel count != H_ACTIVE or with an odd byte count, and err_flags[1] SHALL set when a frame ends with line count != V_ACTIVE.
REQ-032 Macro CMOS_CAPTURE_ERR_EN undefined: err_flags SHALL be constant 0 and no checker logic SHALL be synthesised; the counters kept for frame_cnt remain.

Structure
REQ-033 Package cmos_pkg SHALL hold the FSM state typedef, the RGB565 field width constants and the default H_ACTIVE/V_ACTIVE constants.
REQ-034 Byte pairing and the strobe SHALL live in sub-module cmos_byte_pack; the FSM, counters and checker SHALL stay in the top module.

Verification
REQ-035 Reset release, SKIP_FRAMES=2, 3 frames of 4x2 pixels, cap_en=1 -> no output during frames 1-2; frame 3 gives 8 strobes; frame_cnt=1 after the next vs_rise.
REQ-036 Byte pairs 8'hF8,8'h1F -> cmos_frame_data=16'hF81F, valid a single cycle exactly 2 clocks after the 8'h1F byte.
REQ-037 cap_en dropped mid-frame -> the current frame completes with all strobes; the next frame produces zero strobes.
REQ-038 Line of 7 bytes with H_ACTIVE=4 -> 3 strobes; err_flags[0]=1 with the macro defined, 0 without it.
REQ-039 Frame of 3 lines with V_ACTIVE=2 -> err_flags[1]=1 at vs_rise, held sticky until reset.
REQ-040 sys_rst_n pulsed low mid-line -> all outputs 0 asynchronously, FSM in SKIP, skip count restarts from 0.

Source files
------------

// File: rtl/cmos_pkg.sv
// Shared types and constants for the RGB565 DVP capture block.
package cmos_pkg;

  typedef enum logic [1:0] {
    ST_SKIP   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

  localparam int unsigned R_W   = 5;
  localparam int unsigned G_W   = 6;
  localparam int unsigned B_W   = 5;
  localparam int unsigned PIX_W = R_W + G_W + B_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

endpackage

// File: rtl/cmos_byte_pack.sv
// Pairs consecutive DVP bytes (high byte first) into one RGB565 word and
// emits a single-cycle strobe on the second byte when enabled.
module cmos_byte_pack
  import cmos_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             href_i,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  output logic [PIX_W-1:0] data_o,
  output logic             valid_o
);

  logic             toggle_q, toggle_d;
  logic [7:0]       hi_q, hi_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Toggle falls back to 0 whenever href is low, so an odd trailing byte is dropped.
  always_comb begin
    toggle_d = 1'b0;
    hi_d     = hi_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    if (href_i) begin
      toggle_d = ~toggle_q;
      if (!toggle_q) begin
        hi_d = byte_i;
      end else if (en_i) begin
        data_d  = {hi_q, byte_i};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toggle_q <= 1'b0;
      hi_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cmos_capture_rgb565.sv
// DVP RGB565 capture: settle-frame skip, frame-boundary capture enable, aligned outputs.
// Optional line/frame length checker enabled by defining CMOS_CAPTURE_ERR_EN.
module cmos_capture_rgb565
  import cmos_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE
)(
  input  logic             cmos0_pclk,
  input  logic             sys_rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  input  logic             cap_en,
  output logic             cmos_frame_vsync,
  output logic             cmos_frame_href,
  output logic [PIX_W-1:0] cmos_frame_data,
  output logic             cmos_frame_valid,
  output logic [7:0]       frame_cnt,
  output logic [1:0]       err_flags
);

  logic        vs_q, vs_qq, hr_q, hr_qq;
  logic [7:0]  dat_q;
  cap_state_e  state_q, state_d;
  logic [31:0] skip_q, skip_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        vs_rise, active;

  localparam bit GEOM_OK = (H_ACTIVE > 0) && (V_ACTIVE > 0);

  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q        <= 1'b0;
      vs_qq       <= 1'b0;
      hr_q        <= 1'b0;
      hr_qq       <= 1'b0;
      dat_q       <= '0;
      state_q     <= ST_SKIP;
      skip_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      vs_q        <= cam_vsync;
      vs_qq       <= vs_q;
      hr_q        <= cam_href;
      hr_qq       <= hr_q;
      dat_q       <= cam_data;
      state_q     <= state_d;
      skip_q      <= skip_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vs_rise = vs_q & ~vs_qq;
  assign active  = (state_q == ST_ACTIVE);

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    frame_cnt_d = frame_cnt_q;
    if (vs_rise) begin
      unique case (state_q)
        ST_SKIP: begin
          if (skip_q < SKIP_FRAMES) skip_d = skip_q + 32'd1;
          if (skip_q + 32'd1 >= SKIP_FRAMES) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (cap_en) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (!cap_en) state_d = ST_WAIT;
        end
        default: state_d = ST_SKIP;
      endcase
    end
  end

  cmos_byte_pack u_pack (
    .clk_i   (cmos0_pclk),
    .rst_ni  (sys_rst_n),
    .href_i  (hr_q),
    .en_i    (active),
    .byte_i  (dat_q),
    .data_o  (cmos_frame_data),
    .valid_o (cmos_frame_valid)
  );

  // Two-stage sync copies line up with the packer's strobe latency.
  assign cmos_frame_vsync = vs_qq & active;
  assign cmos_frame_href  = hr_qq & active;
  assign frame_cnt        = frame_cnt_q;

`ifdef CMOS_CAPTURE_ERR_EN
  localparam logic [14:0] H_EXP = 15'(H_ACTIVE);
  localparam logic [15:0] V_EXP = 16'(V_ACTIVE);

  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [1:0]  err_q, err_d;
  logic        hr_fall;

  assign hr_fall = hr_qq & ~hr_q;

  // Bytes are counted rather than strobes: pixels = bytes/2, odd length = bit 0.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    if (hr_q) byte_cnt_d = byte_cnt_q + 16'd1;
    if (hr_fall) begin
      byte_cnt_d = '0;
      line_cnt_d = line_cnt_q + 16'd1;
      if (active && (byte_cnt_q[0] || (byte_cnt_q[15:1] != H_EXP))) err_d[0] = 1'b1;
    end
    if (vs_rise) begin
      line_cnt_d = '0;
      if (active && (line_cnt_q != V_EXP)) err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = '0;
`endif

  geom_ok_a: assert property (@(posedge cmos0_pclk) GEOM_OK);

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Scoreboard bench for cmos_capture_rgb565 (SKIP_FRAMES=2, 4x2 frames).
module tb_cmos_capture_rgb565;

`ifdef CMOS_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef logic [7:0]  bvec_t [8];
  typedef logic [15:0] wvec_t [4];
  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  localparam bvec_t LA_B = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  localparam wvec_t LA_W = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  localparam bvec_t LB_B = '{8'hF8, 8'h1F, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
  localparam wvec_t LB_W = '{16'hF81F, 16'h07E0, 16'h001F, 16'hFFFF};
  localparam bvec_t LC_B = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h00};
  localparam wvec_t LC_W = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0000};

  logic        clk = 1'b0;
  logic        rst_n, vsync, href, cap_en;
  logic [7:0]  data;
  logic        f_vsync, f_href, f_valid;
  logic [15:0] f_data;
  logic [7:0]  f_cnt;
  logic [1:0]  f_err;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmos_capture_rgb565 #(
    .SKIP_FRAMES (2),
    .H_ACTIVE    (4),
    .V_ACTIVE    (2)
  ) dut (
    .cmos0_pclk       (clk),
    .sys_rst_n        (rst_n),
    .cam_vsync        (vsync),
    .cam_href         (href),
    .cam_data         (data),
    .cap_en           (cap_en),
    .cmos_frame_vsync (f_vsync),
    .cmos_frame_href  (f_href),
    .cmos_frame_data  (f_data),
    .cmos_frame_valid (f_valid),
    .frame_cnt        (f_cnt),
    .err_flags        (f_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected pixel, word and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && f_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got strobe data 0x%0h at cycle %0d, required none", f_data, cyc);
      end else begin
        e = sbq.pop_front();
        check("pix_data", 32'(f_data), 32'(e.word));
        check("pix_cycle", cyc, e.cyc);
        check("href_align", 32'(f_href), 32'd1);
      end
    end
  end

  task automatic vsync_pulse(input bit want_vs);
    vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("vsync_out", 32'(f_vsync), 32'(want_vs));
    @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input bvec_t b, input wvec_t w, input int nbytes, input bit cap);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      data = b[i];
      if (cap && (i % 2 == 1)) begin
        e.word = w[i/2];
        e.cyc  = cyc + 2;
        sbq.push_back(e);
      end
      @(negedge clk);
    end
    href = 1'b0;
    data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input bit act);
    vsync_pulse(act);
    send_line(LA_B, LA_W, 8, act);
    send_line(LB_B, LB_W, 8, act);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00; cap_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vsync", 32'(f_vsync), 32'd0);
    check("rst_href", 32'(f_href), 32'd0);
    check("rst_valid", 32'(f_valid), 32'd0);
    check("rst_data", 32'(f_data), 32'd0);
    check("rst_frame_cnt", 32'(f_cnt), 32'd0);
    check("rst_err", 32'(f_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Settle frames, then first captured frame
    send_frame(1'b0);
    send_frame(1'b0);
    send_frame(1'b1);
    check("f3_drained", sbq.size(), 32'd0);
    check("f3_frame_cnt", 32'(f_cnt), 32'd0);

    // Frame 4: cap_en dropped mid-frame must not truncate it
    vsync_pulse(1'b1);
    check("f4_frame_cnt", 32'(f_cnt), 32'd1);
    check("f4_err", 32'(f_err), 32'd0);
    send_line(LA_B, LA_W, 8, 1'b1);
    cap_en = 1'b0;
    send_line(LB_B, LB_W, 8, 1'b1);
    check("f4_drained", sbq.size(), 32'd0);

    // Frame 5: idle
    send_frame(1'b0);
    check("f5_frame_cnt", 32'(f_cnt), 32'd2);
    check("f5_data_hold", 32'(f_data), 32'h0000FFFF);

    // Frame 6: odd-length line and one surplus line
    cap_en = 1'b1;
    vsync_pulse(1'b1);
    check("f6_frame_cnt", 32'(f_cnt), 32'd2);
    send_line(LC_B, LC_W, 7, 1'b1);
    check("line_err", 32'(f_err), {30'd0, 1'b0, ERR_EN});
    send_line(LA_B, LA_W, 8, 1'b1);
    send_line(LB_B, LB_W, 8, 1'b1);
    vsync_pulse(1'b1);
    check("f7_frame_cnt", 32'(f_cnt), 32'd3);
    check("frame_err", 32'(f_err), {30'd0, ERR_EN, ERR_EN});
    send_line(LA_B, LA_W, 8, 1'b1);
    check("err_sticky", 32'(f_err), {30'd0, ERR_EN, ERR_EN});

    // Reset mid-line: pair F8,1F is in flight and must never strobe
    href = 1'b1; data = 8'hF8;
    @(negedge clk);
    data = 8'h1F;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_href", 32'(f_href), 32'd0);
    check("arst_vsync", 32'(f_vsync), 32'd0);
    check("arst_valid", 32'(f_valid), 32'd0);
    check("arst_data", 32'(f_data), 32'd0);
    check("arst_frame_cnt", 32'(f_cnt), 32'd0);
    check("arst_err", 32'(f_err), 32'd0);
    href = 1'b0; data = 8'h00;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full skip sequence again
    send_frame(1'b0);
    send_frame(1'b0);
    send_frame(1'b1);
    check("post_rst_err", 32'(f_err), 32'd0);
    vsync_pulse(1'b1);
    check("post_rst_frame_cnt", 32'(f_cnt), 32'd1);
    check("post_rst_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
